// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder.
package data_mem_pkg;

  // Default number of wait cycles between acceptance and completion.
  localparam int LATENCY_DEFAULT = 2;

  // Width of the latency down-counter (covers LATENCY 0..15).
  localparam int CNT_W = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT         = 2'd1,
    ST_WRITE_COMMIT = 2'd2,
    ST_RESP         = 2'd3
  } state_t;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Word-organised storage with per-byte-lane synchronous write and
// combinational word read. Contents are deliberately never reset.
module mem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (wstrb_i[n]) begin
          mem_q[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory responder: accepts one read or write request at a
// time, waits LATENCY cycles, then commits the write or presents the read
// word until the CPU consumes it.
//
// Handshake: a request is accepted on a rising edge where Mem_Req_Ready=1 and
// (MemRead|MemWrite)=1. A read response is transferred on a rising edge where
// Read_data_Valid=1 and Read_data_Ready=1; Read_data/Read_data_Valid hold
// stable until then, and Read_data_Ready is ignored at any other time.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output state_t      dbg_state_o
);

  // Counter load value on acceptance; zero when the wait phase is skipped.
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  kind_q, kind_d;   // 1 = write, 0 = read
  logic [31:0]           rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_valid;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [31:0]           mem_rdata;
  logic                  mem_we;
  logic                  unused_addr_bits;

  // Byte offset and bits beyond the storage size are dropped, so addresses wrap.
  assign req_idx          = Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
  assign req_valid        = MemRead | MemWrite;
  assign accept           = (state_q == ST_IDLE) && req_valid;

  // With LATENCY=0 a read goes straight from IDLE to RESP, so the word must be
  // looked up from the live address on the accepting edge.
  assign mem_raddr = (state_q == ST_IDLE) ? req_idx : addr_q;
  assign mem_we    = (state_q == ST_WRITE_COMMIT);

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      kind_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      kind_q  <= kind_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; a simultaneous read+write is handled as a write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0)   state_d = ST_WAIT;
          else if (MemWrite) state_d = ST_WRITE_COMMIT;
          else               state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = kind_q ? ST_WRITE_COMMIT : ST_RESP;
      end
      ST_WRITE_COMMIT: state_d = ST_IDLE;
      ST_RESP: begin
        if (Read_data_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, latency counter and read-data capture.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    kind_d  = kind_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = CNT_INIT;
      addr_d  = req_idx;
      wdata_d = Write_data;
      wstrb_d = Write_strb;
      kind_d  = MemWrite;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      rdata_d = mem_rdata;
    end else if ((state_q == ST_RESP) && (state_d != ST_RESP)) begin
      rdata_d = '0;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    Mem_Req_Ready   = (state_q == ST_IDLE);
    Read_data_Valid = (state_q == ST_RESP);
    Read_data       = (state_q == ST_RESP) ? rdata_q : '0;
    dbg_state_o     = state_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with LATENCY=2 and one with
// LATENCY=0 share the stimulus bus; 'sel' steers requests to one of them.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemWrite, MemRead, Read_data_Ready;
  logic        sel;   // 0: LATENCY=2 instance, 1: LATENCY=0 instance

  logic        mw2, mr2, rr2, mw0, mr0, rr0;
  logic        rdy2, v2, rdy0, v0;
  logic [31:0] rd2, rd0;
  state_t      st2, st0;

  assign mw2 = MemWrite & ~sel;
  assign mr2 = MemRead & ~sel;
  assign rr2 = Read_data_Ready & ~sel;
  assign mw0 = MemWrite & sel;
  assign mr0 = MemRead & sel;
  assign rr0 = Read_data_Ready & sel;

  logic        m_ready, m_valid;
  logic [31:0] m_rdata;
  state_t      m_state;
  assign m_ready = sel ? rdy0 : rdy2;
  assign m_valid = sel ? v0 : v2;
  assign m_rdata = sel ? rd0 : rd2;
  assign m_state = sel ? st0 : st2;

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .Address(Address), .MemWrite(mw2), .MemRead(mr2),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(rdy2),
    .Read_data(rd2), .Read_data_Valid(v2), .Read_data_Ready(rr2), .dbg_state_o(st2)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .Address(Address), .MemWrite(mw0), .MemRead(mr0),
    .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(rdy0),
    .Read_data(rd0), .Read_data_Valid(v0), .Read_data_Ready(rr0), .dbg_state_o(st0)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // ---------------- driver ----------------
  // Issues one request to the selected instance and observes it until the
  // instance is ready again. Read_data_Ready is held low for 'hold' cycles of
  // Read_data_Valid and then raised.
  task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input int hold,
                         output int busy, output int valid_at, output logic [31:0] rdata,
                         output logic stable, output logic timeout, output logic nz_idle);
    int n;
    busy = 0; valid_at = -1; rdata = '0; stable = 1'b1; timeout = 1'b0; nz_idle = 1'b0;
    n = 0;
    @(negedge clk);
    Read_data_Ready = (hold == 0);
    Address = addr; Write_data = data; Write_strb = strb; MemWrite = wr; MemRead = rd;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    while (1) begin
      @(negedge clk);
      n++;
      if (!m_valid && (m_rdata !== 32'd0)) nz_idle = 1'b1;
      if (m_ready) break;
      busy++;
      if (m_valid) begin
        if (valid_at < 0) begin
          valid_at = n;
          rdata = m_rdata;
        end else if (m_rdata !== rdata) begin
          stable = 1'b0;
        end
        if (n - valid_at >= hold) Read_data_Ready = 1'b1;
      end
      if (n > 60) begin
        timeout = 1'b1;
        break;
      end
    end
    Read_data_Ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready_l2: got %b want 1", rdy2); end
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL reset_valid_l2: got %b want 0", v2); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_rdata_l2: got %h want 0", rd2); end
    checks++; if (st2 !== ST_IDLE) begin errors++; $display("FAIL reset_state_l2: got %0d want %0d", st2, ST_IDLE); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready_l0: got %b want 1", rdy0); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid_l0: got %b want 0", v0); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", rdy2); end
  endtask

  task automatic test_basic;
    int busy, va; logic [31:0] rd, exp; logic st, to, nz;
    sel = 1'b0;
    run_txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 0, busy, va, rd, st, to, nz);
    checks++; if (busy !== 3) begin errors++; $display("FAIL basic_write_busy: got %0d want 3", busy); end
    checks++; if (va !== -1) begin errors++; $display("FAIL basic_write_novalid: got %0d want -1", va); end
    exp_q.push_back(32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 0, busy, va, rd, st, to, nz);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_read_timeout: got %b want 0", to); end
    checks++; if (va !== 3) begin errors++; $display("FAIL basic_read_latency: got %0d want 3", va); end
    checks++; if (busy !== 3) begin errors++; $display("FAIL basic_read_busy: got %0d want 3", busy); end
    checks++; if (nz !== 1'b0) begin errors++; $display("FAIL basic_rdata_zero_idle: got %b want 0", nz); end
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL basic_read_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_byte_lanes;
    int busy, va; logic [31:0] rd, exp; logic st, to, nz;
    sel = 1'b0;
    run_txn(1'b1, 1'b0, 32'h20, 32'h00000000, 4'hF, 0, busy, va, rd, st, to, nz);
    run_txn(1'b1, 1'b0, 32'h20, 32'h00AB0000, 4'b0100, 0, busy, va, rd, st, to, nz);
    exp_q.push_back(32'h00AB0000);
    run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 0, busy, va, rd, st, to, nz);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL lane2_data: got %h want %h", rd, exp); end
    run_txn(1'b1, 1'b0, 32'h24, 32'h11223344, 4'hF, 0, busy, va, rd, st, to, nz);
    run_txn(1'b1, 1'b0, 32'h24, 32'hFFFFFFAA, 4'b0001, 0, busy, va, rd, st, to, nz);
    run_txn(1'b1, 1'b0, 32'h24, 32'hEEEEEEEE, 4'b0000, 0, busy, va, rd, st, to, nz);
    checks++; if (busy !== 3) begin errors++; $display("FAIL zero_strb_busy: got %0d want 3", busy); end
    exp_q.push_back(32'h112233AA);
    run_txn(1'b0, 1'b1, 32'h24, 32'h0, 4'h0, 0, busy, va, rd, st, to, nz);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL lane0_zero_strb_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_backpressure;
    int busy, va; logic [31:0] rd, exp; logic st, to, nz;
    sel = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 5, busy, va, rd, st, to, nz);
    checks++; if (va !== 3) begin errors++; $display("FAIL bp_latency: got %0d want 3", va); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", st); end
    checks++; if (busy !== 8) begin errors++; $display("FAIL bp_busy: got %0d want 8", busy); end
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL bp_data: got %h want %h", rd, exp); end
  endtask

  task automatic test_simultaneous;
    int busy, va; logic [31:0] rd, exp; logic st, to, nz;
    sel = 1'b0;
    run_txn(1'b1, 1'b1, 32'h8, 32'h00001234, 4'hF, 0, busy, va, rd, st, to, nz);
    checks++; if (va !== -1) begin errors++; $display("FAIL rw_no_resp: got valid at %0d want none", va); end
    checks++; if (busy !== 3) begin errors++; $display("FAIL rw_busy: got %0d want 3", busy); end
    exp_q.push_back(32'h00001234);
    run_txn(1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 0, busy, va, rd, st, to, nz);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL rw_readback: got %h want %h", rd, exp); end
  endtask

  task automatic test_zero_latency;
    int busy, va; logic [31:0] rd, exp; logic st, to, nz;
    sel = 1'b1;
    run_txn(1'b1, 1'b0, 32'h400, 32'h00000055, 4'hF, 0, busy, va, rd, st, to, nz);
    checks++; if (busy !== 1) begin errors++; $display("FAIL l0_write_busy: got %0d want 1", busy); end
    exp_q.push_back(32'h00000055);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 0, busy, va, rd, st, to, nz);
    checks++; if (va !== 1) begin errors++; $display("FAIL l0_read_latency: got %0d want 1", va); end
    checks++; if (busy !== 1) begin errors++; $display("FAIL l0_read_busy: got %0d want 1", busy); end
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL l0_wrap_data: got %h want %h", rd, exp); end
    exp_q.push_back(32'h00000055);
    run_txn(1'b0, 1'b1, 32'hFFFFFC03, 32'h0, 4'h0, 2, busy, va, rd, st, to, nz);
    checks++; if (busy !== 3) begin errors++; $display("FAIL l0_bp_busy: got %0d want 3", busy); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL l0_bp_stable: got %b want 1", st); end
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL l0_highbits_data: got %h want %h", rd, exp); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int busy, va, n; logic [31:0] rd, exp; logic st, to, nz;
    sel = 1'b0;
    run_txn(1'b1, 1'b0, 32'h30, 32'h00001111, 4'hF, 0, busy, va, rd, st, to, nz);
    // Start an overwrite and abort it during WAIT.
    @(negedge clk);
    Address = 32'h30; Write_data = 32'hFFFFFFFF; Write_strb = 4'hF; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    @(negedge clk);
    checks++; if (st2 !== ST_WAIT) begin errors++; $display("FAIL mid_wait_state: got %0d want %0d", st2, ST_WAIT); end
    rst = 1'b0;
    #1;
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL mid_wait_reset_ready: got %b want 1", rdy2); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL mid_wait_release_ready: got %b want 1", rdy2); end
    exp_q.push_back(32'h00001111);
    run_txn(1'b0, 1'b1, 32'h30, 32'h0, 4'h0, 0, busy, va, rd, st, to, nz);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL mid_wait_no_commit: got %h want %h", rd, exp); end
    // Start a read, stall in RESP, then reset.
    @(negedge clk);
    Address = 32'h30; MemRead = 1'b1; Read_data_Ready = 1'b0;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
    n = 0;
    while (!v2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL mid_resp_reached: got %b want 1", v2); end
    rst = 1'b0;
    #1;
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL mid_resp_reset_valid: got %b want 0", v2); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL mid_resp_reset_rdata: got %h want 0", rd2); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL mid_resp_no_pending: got %b want 0", v2); end
    checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL mid_resp_ready: got %b want 1", rdy2); end
  endtask

  task automatic test_random;
    logic [31:0] model [16];
    int busy, va, i, hold;
    logic [31:0] rd, exp, addr, d;
    logic [3:0] s;
    logic st, to, nz;
    sel = 1'b0;
    for (int k = 0; k < 16; k++) begin
      model[k] = $urandom;
      run_txn(1'b1, 1'b0, 32'((64 + k) * 4), model[k], 4'hF, 0, busy, va, rd, st, to, nz);
    end
    for (int k = 0; k < 24; k++) begin
      i = $urandom_range(0, 15);
      addr = {22'($urandom), 8'(64 + i), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
        run_txn(1'b1, 1'b0, addr, d, s, 0, busy, va, rd, st, to, nz);
        checks++; if (busy !== 3) begin errors++; $display("FAIL rnd_write_busy: got %0d want 3", busy); end
      end else begin
        hold = $urandom_range(0, 3);
        exp_q.push_back(model[i]);
        run_txn(1'b0, 1'b1, addr, 32'h0, 4'h0, hold, busy, va, rd, st, to, nz);
        checks++; if (va !== 3) begin errors++; $display("FAIL rnd_read_latency: got %0d want 3", va); end
        checks++; if (busy !== 3 + hold) begin errors++; $display("FAIL rnd_read_busy: got %0d want %0d", busy, 3 + hold); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL rnd_read_stable: got %b want 1", st); end
        exp = exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL rnd_read_data: addr %h got %h want %h", addr, rd, exp); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    Address = '0; Write_data = '0; Write_strb = '0;
    MemWrite = 1'b0; MemRead = 1'b0; Read_data_Ready = 1'b0; sel = 1'b0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_backpressure();
    test_simultaneous();
    test_zero_latency();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
